// File: rtl/cache_line_resp_pkg.sv
// Shared types and constants for the cache line responder.
package cache_line_resp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        R_WAIT,
        R_BEAT,
        W_DATA,
        W_RESP
    } state_e;

    localparam int unsigned LINE_WORDS  = 16;
    localparam int unsigned BEAT_W      = 4;
    localparam int unsigned LINE_OFFSET = 6;
    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned STRB_W      = DATA_W / 8;
    localparam int unsigned LINE_W      = ADDR_W - LINE_OFFSET;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    // Full-width word number of a beat within a line; callers truncate to store size.
    function automatic logic [LINE_W+BEAT_W-1:0] word_addr(
        input logic [LINE_W-1:0] line,
        input logic [BEAT_W-1:0] beat
    );
        return {line, beat};
    endfunction

endpackage

// File: rtl/cache_line_responder_mem.sv
// Word-addressed backing store: byte-enabled write port, registered read port.
module line_mem_array
    import cache_line_resp_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic [STRB_W-1:0]    wr_strb,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [DATA_W-1:0]    rd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < int'(STRB_W); i++) begin
                if (wr_strb[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // Only the read register is reset; stored contents survive reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/cache_line_responder.sv
// Line refill / write-back responder serving 16-beat bursts from on-chip memory.
module cache_line_responder
    import cache_line_resp_pkg::*;
#(
    parameter int unsigned MEM_WORDS_LOG2 = 14,
    parameter int unsigned READ_LATENCY   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r_req,
    input  logic [ADDR_W-1:0] r_addr,
    output logic              r_rdy,
    output logic              ret_valid,
    output logic              ret_last,
    output logic [DATA_W-1:0] r_data,
    input  logic              r_data_ready,
    input  logic              w_req,
    input  logic [ADDR_W-1:0] w_addr,
    output logic              w_rdy,
    input  logic              w_data_req,
    input  logic [DATA_W-1:0] w_data,
    input  logic [STRB_W-1:0] w_strb,
    input  logic              w_last,
    output logic              w_data_ready,
    output logic              b_valid,
    input  logic              b_ready,
    output logic              proto_err
);

    localparam int unsigned LAT_W = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);

    state_e              state;
    logic [LINE_W-1:0]   line;
    logic [BEAT_W-1:0]   beat;
    logic [LAT_W-1:0]    lat_cnt;

    logic                r_beat_acc;
    logic                w_beat_acc;
    logic                rd_en;
    logic [BEAT_W-1:0]   rd_beat;
    logic                wr_en;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^{r_addr[LINE_OFFSET-1:0], w_addr[LINE_OFFSET-1:0]};

    // Writes win arbitration so a victim lands before its refill.
    assign w_rdy = (state == IDLE);
    assign r_rdy = (state == IDLE) && !w_req;

    assign r_beat_acc = ret_valid && r_data_ready;
    assign w_beat_acc = w_data_req && w_data_ready;
    assign wr_en      = (state == W_DATA) && w_beat_acc;

    // First fetch on R_BEAT entry, then prefetch the next word on each accept.
    always_comb begin
        rd_en   = 1'b0;
        rd_beat = beat;
        if (state == R_BEAT) begin
            if (!ret_valid) begin
                rd_en = 1'b1;
            end else if (r_beat_acc && !ret_last) begin
                rd_en   = 1'b1;
                rd_beat = beat + BEAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            line         <= '0;
            beat         <= '0;
            lat_cnt      <= '0;
            ret_valid    <= 1'b0;
            ret_last     <= 1'b0;
            w_data_ready <= 1'b0;
            b_valid      <= 1'b0;
            proto_err    <= 1'b0;
        end else begin
            if (rd_en) ret_last <= (rd_beat == LAST_BEAT);
            case (state)
                IDLE: begin
                    if (w_req) begin
                        line         <= w_addr[ADDR_W-1:LINE_OFFSET];
                        beat         <= '0;
                        w_data_ready <= 1'b1;
                        state        <= W_DATA;
                    end else if (r_req) begin
                        line    <= r_addr[ADDR_W-1:LINE_OFFSET];
                        beat    <= '0;
                        lat_cnt <= LAT_W'(READ_LATENCY);
                        state   <= (READ_LATENCY == 0) ? R_BEAT : R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (lat_cnt == LAT_W'(1)) begin
                        state <= R_BEAT;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                R_BEAT: begin
                    if (!ret_valid) begin
                        ret_valid <= 1'b1;
                    end else if (r_beat_acc) begin
                        if (ret_last) begin
                            ret_valid <= 1'b0;
                            ret_last  <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            beat <= beat + BEAT_W'(1);
                        end
                    end
                end
                W_DATA: begin
                    if (w_beat_acc) begin
                        beat <= beat + BEAT_W'(1);
                        if (w_last) begin
                            w_data_ready <= 1'b0;
                            b_valid      <= 1'b1;
                            state        <= W_RESP;
                            if (beat != LAST_BEAT) proto_err <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (b_ready) begin
                        b_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    line_mem_array #(
        .ADDR_BITS (MEM_WORDS_LOG2)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (MEM_WORDS_LOG2'(word_addr(line, beat))),
        .wr_data (w_data),
        .wr_strb (w_strb),
        .rd_en   (rd_en),
        .rd_addr (MEM_WORDS_LOG2'(word_addr(line, rd_beat))),
        .rd_data (r_data)
    );

endmodule

// File: tb/tb_cache_line_responder.sv
// Randomized bench for cache_line_responder against a word-array reference model.
module tb_cache_line_responder;

    localparam int unsigned MEM_LOG2 = 14;
    localparam int unsigned LAT      = 2;
    localparam int unsigned DEPTH    = 1 << MEM_LOG2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r_req = 1'b0;
    logic [31:0] r_addr = '0;
    logic        r_rdy;
    logic        ret_valid;
    logic        ret_last;
    logic [31:0] r_data;
    logic        r_data_ready = 1'b0;
    logic        w_req = 1'b0;
    logic [31:0] w_addr = '0;
    logic        w_rdy;
    logic        w_data_req = 1'b0;
    logic [31:0] w_data = '0;
    logic [3:0]  w_strb = '0;
    logic        w_last = 1'b0;
    logic        w_data_ready;
    logic        b_valid;
    logic        b_ready = 1'b0;
    logic        proto_err;

    int          vectors = 0;
    int          miscompares = 0;
    logic        exp_proto = 1'b0;
    logic [31:0] model [int];
    logic [31:0] wdat [16];
    logic [3:0]  wstb [16];

    cache_line_responder #(
        .MEM_WORDS_LOG2 (MEM_LOG2),
        .READ_LATENCY   (LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .r_req        (r_req),
        .r_addr       (r_addr),
        .r_rdy        (r_rdy),
        .ret_valid    (ret_valid),
        .ret_last     (ret_last),
        .r_data       (r_data),
        .r_data_ready (r_data_ready),
        .w_req        (w_req),
        .w_addr       (w_addr),
        .w_rdy        (w_rdy),
        .w_data_req   (w_data_req),
        .w_data       (w_data),
        .w_strb       (w_strb),
        .w_last       (w_last),
        .w_data_ready (w_data_ready),
        .b_valid      (b_valid),
        .b_ready      (b_ready),
        .proto_err    (proto_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Store word index of beat k of the line holding addr, wrapping at store size.
    function automatic int widx(input logic [31:0] addr, input int k);
        logic [31:0] base;
        base = (addr >> 6) << 4;
        return int'((base + 32'(k)) & 32'(DEPTH - 1));
    endfunction

    function automatic logic [31:0] mword(input int idx);
        return model.exists(idx) ? model[idx] : 32'h0;
    endfunction

    task automatic check_reset_values();
        check("rst_ret_valid", 32'(ret_valid), 0);
        check("rst_ret_last", 32'(ret_last), 0);
        check("rst_r_data", r_data, 0);
        check("rst_w_data_ready", 32'(w_data_ready), 0);
        check("rst_b_valid", 32'(b_valid), 0);
        check("rst_proto_err", 32'(proto_err), 0);
        check("rst_r_rdy", 32'(r_rdy), 1);
        check("rst_w_rdy", 32'(w_rdy), 1);
    endtask

    task automatic do_write(input logic [31:0] addr, input int last_beat);
        int          n;
        int          idx;
        logic [31:0] v;
        n = 0;
        w_req  = 1'b1;
        w_addr = addr;
        while (!w_rdy && n < 50) begin tick(); n++; end
        if (!w_rdy) begin
            check("w_rdy_timeout", 32'(w_rdy), 1);
            w_req = 1'b0;
            return;
        end
        tick();
        w_req = 1'b0;
        for (int b = 0; b <= last_beat; b++) begin
            w_data_req = 1'b1;
            w_data     = wdat[b];
            w_strb     = wstb[b];
            w_last     = (b == last_beat);
            n = 0;
            while (!w_data_ready && n < 50) begin tick(); n++; end
            if (!w_data_ready) begin
                check("w_data_ready_timeout", 32'(w_data_ready), 1);
                w_data_req = 1'b0;
                w_last     = 1'b0;
                return;
            end
            if (b == last_beat) check("b_valid_early", 32'(b_valid), 0);
            tick();
            idx = widx(addr, b);
            v   = mword(idx);
            for (int j = 0; j < 4; j++) begin
                if (wstb[b][j]) v[8*j +: 8] = wdat[b][8*j +: 8];
            end
            model[idx] = v;
        end
        w_data_req = 1'b0;
        w_last     = 1'b0;
        if (last_beat != 15) exp_proto = 1'b1;
        check("b_valid_rise", 32'(b_valid), 1);
        check("w_data_ready_drop", 32'(w_data_ready), 0);
        check("proto_err", 32'(proto_err), 32'(exp_proto));
        n = int'($urandom_range(0, 2));
        for (int i = 0; i < n; i++) begin
            check("b_valid_hold", 32'(b_valid), 1);
            tick();
        end
        b_ready = 1'b1;
        tick();
        b_ready = 1'b0;
        check("b_valid_fall", 32'(b_valid), 0);
    endtask

    // mode 0: always ready, 1: alternate 1/0, 2: random; abort_at >= 0 resets on that beat.
    task automatic do_read(input logic [31:0] addr, input int mode, input int abort_at);
        logic [31:0] exp [16];
        int          n;
        int          accepted;
        int          cyc;
        logic        rdy;
        for (int k = 0; k < 16; k++) exp[k] = mword(widx(addr, k));
        n = 0;
        r_req  = 1'b1;
        r_addr = addr;
        while (!r_rdy && n < 50) begin tick(); n++; end
        if (!r_rdy) begin
            check("r_rdy_timeout", 32'(r_rdy), 1);
            r_req = 1'b0;
            return;
        end
        tick();
        r_req = 1'b0;
        for (int i = 0; i <= int'(LAT); i++) begin
            check("r_latency", 32'(ret_valid), 0);
            tick();
        end
        accepted = 0;
        cyc      = 0;
        while (accepted < 16 && cyc < 200) begin
            if (accepted == abort_at) begin
                rst          = 1'b1;
                r_data_ready = 1'b0;
                tick();
                rst       = 1'b0;
                exp_proto = 1'b0;
                check_reset_values();
                return;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            r_data_ready = rdy;
            check("ret_valid", 32'(ret_valid), 1);
            check("r_data", r_data, exp[accepted]);
            check("ret_last", 32'(ret_last), 32'(accepted == 15));
            tick();
            if (rdy) accepted++;
            cyc++;
        end
        r_data_ready = 1'b0;
        if (accepted < 16) check("r_beats_timeout", 32'(accepted), 16);
        check("ret_valid_end", 32'(ret_valid), 0);
    endtask

    task automatic fill(input logic [31:0] addr, input logic [31:0] step, input logic [31:0] fixed);
        for (int k = 0; k < 16; k++) begin
            wdat[k] = (step != 0) ? 32'(widx(addr, k)) * step : fixed;
            wstb[k] = 4'hF;
        end
    endtask

    initial begin
        logic [31:0] addr;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        check_reset_values();

        // Preload: word[i] = i * 0x01010101 on the lines under test, 0x12345678 on line 0x80
        fill(32'h0000_0000, 32'h0101_0101, 0); do_write(32'h0000_0000, 15);
        fill(32'h0000_0040, 32'h0101_0101, 0); do_write(32'h0000_0040, 15);
        fill(32'h0000_0080, 0, 32'h1234_5678); do_write(32'h0000_0080, 15);
        fill(32'h0000_00C0, 32'h0101_0101, 0); do_write(32'h0000_00C0, 15);

        // Plain refill, then with alternating backpressure, low offset bits ignored
        do_read(32'h0000_0040, 0, -1);
        do_read(32'h0000_007F, 1, -1);

        // Byte-strobed write-back merge
        for (int k = 0; k < 16; k++) begin
            wdat[k] = 32'hA5A5_A5A5;
            wstb[k] = 4'b0011;
        end
        do_write(32'h0000_0080, 15);
        do_read(32'h0000_0080, 0, -1);

        // Simultaneous request: write wins, read then sees the new data
        for (int k = 0; k < 16; k++) begin
            wdat[k] = $urandom;
            wstb[k] = 4'hF;
        end
        r_req  = 1'b1;
        r_addr = 32'h0000_0080;
        w_req  = 1'b1;
        w_addr = 32'h0000_0080;
        #1;
        check("arb_r_rdy", 32'(r_rdy), 0);
        check("arb_w_rdy", 32'(w_rdy), 1);
        do_write(32'h0000_0080, 15);
        do_read(32'h0000_0080, 0, -1);

        // Reset in the middle of a burst, then a fresh read
        do_read(32'h0000_0040, 0, 5);
        do_read(32'h0000_0040, 2, -1);

        // Early w_last sets the sticky error until reset
        for (int k = 0; k < 16; k++) begin
            wdat[k] = $urandom;
            wstb[k] = 4'(1 << (k % 4));
        end
        do_write(32'h0000_00C0, 7);
        do_read(32'h0000_00C0, 2, -1);
        check("proto_err_sticky", 32'(proto_err), 1);
        fill(32'h0000_0000, 32'h0101_0101, 0);
        do_write(32'h0000_0000, 15);
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        exp_proto = 1'b0;
        check("proto_err_cleared", 32'(proto_err), 0);

        // Random lines: full write, strobed overwrite, readback, and an aliased readback
        for (int r = 0; r < 6; r++) begin
            addr = $urandom & 32'hFFFF_FFC0;
            for (int k = 0; k < 16; k++) begin
                wdat[k] = $urandom;
                wstb[k] = 4'hF;
            end
            do_write(addr, 15);
            for (int k = 0; k < 16; k++) begin
                wdat[k] = $urandom;
                wstb[k] = 4'($urandom_range(0, 15));
            end
            do_write(addr, 15);
            do_read(addr, r % 3, -1);
            do_read(addr ^ 32'h8010_0000, 2, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
